// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver: FSM state type, oversampling
// constants and the 2-of-3 vote helper used when majority sampling is built in.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int CNT_W      = $clog2(OVERSAMPLE);

   // Sample points expressed in the tick counter's own width.
   localparam logic [CNT_W-1:0] START_MID = CNT_W'(7);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(15);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Multi-flop synchroniser bringing the asynchronous serial line into the clk
// domain. Flops reset to 1 so the line reads as idle while reset is applied.
// SYNC_STAGES must be at least 2.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   d      asynchronous input
//   q      synchronised output
// -----------------------------------------------------------------------------
module uart_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '1;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver using a 16x oversampling tick. The line is synchronised,
// the start bit is qualified at its middle, data bits are sampled LSB first
// at the middle of each bit and the stop bit decides between a good byte
// (rx_valid pulse) and a framing error (frame_err pulse).
//
// Configuration macro:
//   UART_RX_MAJORITY_EN  when defined, every bit value is the 2-of-3 majority
//                        of the last three tick samples ending at the sample
//                        point; otherwise the single sample is used.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial line, idle high
//   tick_16x   one-clk pulse at 16x the baud rate
//   rx_data    last good byte, held until overwritten
//   rx_valid   one-clk pulse when rx_data updates
//   frame_err  one-clk pulse on a bad (low) stop bit
//   rx_busy    high from start detect until back in IDLE
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 tick_16x,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 bit_val;
   rx_state_t            state;
   logic [CNT_W-1:0]     cnt;
   logic [2:0]           bit_idx;
   logic                 armed;
   logic [DATA_BITS-1:0] shift_reg;

   uart_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rx),
      .q    (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // Two previous tick samples; together with the current rx_s they cover the
   // three ticks ending at any sample point (cnt 5,6,7 or 13,14,15).
   logic [1:0] vote_hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vote_hist <= 2'b11;
      end else if (tick_16x) begin
         vote_hist <= {vote_hist[0], rx_s};
      end
   end

   assign bit_val = majority3(vote_hist[1], vote_hist[0], rx_s);
`else
   assign bit_val = rx_s;
`endif

   // Receiver FSM. Everything advances only on tick_16x; the result pulses
   // default low every clk so they last exactly one clk. The armed flag
   // requires the line to be seen high before a start bit is accepted, which
   // keeps a held-low line (break) after a framing error or reset from
   // being mistaken for a stream of start bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         armed     <= 1'b0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (tick_16x) begin
            unique case (state)
               IDLE: begin
                  cnt <= '0;
                  if (rx_s) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     state   <= START;
                     armed   <= 1'b0;
                     rx_busy <= 1'b1;
                  end
               end

               START: begin
                  if (cnt == START_MID) begin
                     cnt <= '0;
                     if (bit_val) begin
                        // Line went back high mid start bit: treat as glitch.
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                     end else begin
                        state   <= DATA;
                        bit_idx <= '0;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end

               DATA: begin
                  // Counter wraps 15->0 naturally, re-aligning to each bit middle.
                  cnt <= cnt + 1'b1;
                  if (cnt == BIT_LAST) begin
                     shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                     bit_idx   <= bit_idx + 3'd1;
                     if (bit_idx == LAST_BIT_IDX) begin
                        state <= STOP;
                     end
                  end
               end

               STOP: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == BIT_LAST) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                     if (bit_val) begin
                        rx_data  <= shift_reg;
                        rx_valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed testbench for uart_rx. The line is driven in "slots" of four clk
// cycles, one tick_16x per slot, so sixteen slots make one bit time. A
// monitor counts result pulses and logs received bytes; expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       tick_16x;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   int checks = 0;
   int errors = 0;

   int         valid_count = 0;
   int         err_count   = 0;
   int         both_count  = 0;
   int         start_count = 0;
   logic       busy_prev   = 1'b0;
   logic [7:0] data_log[$];

`ifdef UART_RX_MAJORITY_EN
   localparam logic [7:0] EXP_GLITCH = 8'h55;
`else
   localparam logic [7:0] EXP_GLITCH = 8'hAA;
`endif

   uart_rx #(
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (rx),
      .tick_16x (tick_16x),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .rx_busy  (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watch DUT outputs shortly after each rising edge: count pulses, log
   // received bytes and count start detections (rx_busy rising).
   always @(posedge clk) begin
      #2;
      if (rx_valid) begin
         valid_count++;
         data_log.push_back(rx_data);
      end
      if (frame_err) err_count++;
      if (rx_valid && frame_err) both_count++;
      if (rx_busy && !busy_prev) start_count++;
      busy_prev = rx_busy;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive the line to 'value' for 'slots' tick periods; the tick of each
   // slot samples that slot's value after the two-flop synchroniser.
   task automatic applyStimulus(input logic value, input int slots);
      repeat (slots) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rx       = value;
            tick_16x = (c == 3);
         end
      end
   endtask

   // Full 8N1 frame. With glitch set, each data bit is inverted for the one
   // slot that lands on its mid-bit sample tick.
   task automatic sendFrame(input logic [7:0] data, input logic stop_val,
                            input logic glitch);
      applyStimulus(1'b0, 16);
      for (int i = 0; i < 8; i++) begin
         if (glitch) begin
            applyStimulus(data[i], 8);
            applyStimulus(~data[i], 1);
            applyStimulus(data[i], 7);
         end else begin
            applyStimulus(data[i], 16);
         end
      end
      applyStimulus(stop_val, 16);
   endtask

   initial begin
      int v0;
      int e0;
      int s0;
      int n0;

      rx       = 1'b1;
      tick_16x = 1'b0;
      rst_n    = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_rx_data", rx_data, 8'h00);
      checkOutput("reset_rx_valid", rx_valid, 1'b0);
      checkOutput("reset_frame_err", frame_err, 1'b0);
      checkOutput("reset_rx_busy", rx_busy, 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 20);

      // Basic byte
      v0 = valid_count;
      sendFrame(8'hA5, 1'b1, 1'b0);
      applyStimulus(1'b1, 4);
      checkOutput("a5_valid_count", valid_count, v0 + 1);
      checkOutput("a5_rx_data", rx_data, 8'hA5);
      checkOutput("a5_no_frame_err", err_count, 0);

      // Short low pulse rejected at the start-bit middle
      v0 = valid_count;
      s0 = start_count;
      applyStimulus(1'b0, 2);
      checkOutput("glitch_busy_during", rx_busy, 1'b1);
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 12);
      checkOutput("glitch_busy_after", rx_busy, 1'b0);
      checkOutput("glitch_no_valid", valid_count, v0);
      checkOutput("glitch_no_err", err_count, 0);
      checkOutput("glitch_one_start", start_count, s0 + 1);

      // Framing error followed by a held-low break, then a good frame
      v0 = valid_count;
      e0 = err_count;
      sendFrame(8'h3C, 1'b0, 1'b0);
      checkOutput("ferr_err_count", err_count, e0 + 1);
      checkOutput("ferr_no_valid", valid_count, v0);
      checkOutput("ferr_data_kept", rx_data, 8'hA5);
      s0 = start_count;
      applyStimulus(1'b0, 40);
      checkOutput("break_no_start", start_count, s0);
      checkOutput("break_not_busy", rx_busy, 1'b0);
      applyStimulus(1'b1, 10);
      sendFrame(8'h81, 1'b1, 1'b0);
      applyStimulus(1'b1, 4);
      checkOutput("after_break_valid", valid_count, v0 + 1);
      checkOutput("after_break_data", rx_data, 8'h81);
      checkOutput("after_break_err", err_count, e0 + 1);

      // Reset in the middle of data bit 4 of an 8'hFF frame
      v0 = valid_count;
      e0 = err_count;
      applyStimulus(1'b0, 16);
      applyStimulus(1'b1, 72);
      @(negedge clk);
      tick_16x = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("midreset_busy", rx_busy, 1'b0);
      checkOutput("midreset_data", rx_data, 8'h00);
      rst_n = 1'b1;
      applyStimulus(1'b1, 20);
      checkOutput("abort_no_valid", valid_count, v0);
      checkOutput("abort_no_err", err_count, e0);
      sendFrame(8'h12, 1'b1, 1'b0);
      applyStimulus(1'b1, 4);
      checkOutput("post_reset_valid", valid_count, v0 + 1);
      checkOutput("post_reset_data", rx_data, 8'h12);

      // Single-tick inversion at every data mid-sample
      sendFrame(8'h55, 1'b1, 1'b1);
      applyStimulus(1'b1, 4);
      checkOutput("glitch_bits_data", rx_data, EXP_GLITCH);

      // Back-to-back frames without an idle gap
      n0 = data_log.size();
      sendFrame(8'h00, 1'b1, 1'b0);
      sendFrame(8'hFF, 1'b1, 1'b0);
      sendFrame(8'h7E, 1'b1, 1'b0);
      applyStimulus(1'b1, 4);
      checkOutput("b2b_count", data_log.size(), n0 + 3);
      if (data_log.size() >= n0 + 3) begin
         checkOutput("b2b_byte0", data_log[n0], 8'h00);
         checkOutput("b2b_byte1", data_log[n0 + 1], 8'hFF);
         checkOutput("b2b_byte2", data_log[n0 + 2], 8'h7E);
      end

      checkOutput("never_both_pulses", both_count, 0);

      @(negedge clk);
      tick_16x = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
